adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 20 ++
 rtl/adder_arbiter_rr_pick.sv | 35 +++
 rtl/adder_arbiter.sv | 115 +++++++++++
 tb/tb_adder_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block: FSM state encoding,
// requester count and a small index-to-one-hot helper.
package adder_arbiter_pkg;

  localparam int unsigned N_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [2:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req   [7:0] request vector, bit i = requester i
//   ptr   [2:0] search start position
//   valid       any request present
//   idx   [2:0] first requester at or after ptr (wrapping 7->0)
module rr_pick
  import adder_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [2:0]         w_off;

  // Rotating so that ptr lands on bit 0 turns the round-robin search
  // into a plain lowest-bit-first priority encode.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: N_REQ];

  always_comb begin
    w_off = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (w_rot[i-1]) w_off = 3'(i - 1);
    end
  end

  assign valid = |req;
  assign idx   = ptr + w_off;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of a single shared adder.
// One requester is granted in IDLE, its operands are added in EXEC and
// the result is presented with a one-cycle ack in DONE.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req   [7:0]     request levels
//   op_a/op_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt   [7:0]     one-hot grant, held IDLE->EXEC->DONE
//   ack   [7:0]     one-hot completion pulse (DONE cycle)
//   sum, cout       (A+B) result and carry, held between transactions
//   busy            state is not IDLE
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   busy
);

  state_t             r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0]   r_ack, w_ack_nxt;
  logic [WIDTH-1:0]   r_sum, w_sum_nxt;
  logic               r_cout, w_cout_nxt;
  logic [2:0]         r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;

  logic               w_valid;
  logic [2:0]         w_idx;
  logic [WIDTH:0]     w_add;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // Single adder, always fed from the latched operands.
  assign w_add = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_ptr_nxt   = r_ptr;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_nxt   = idx2onehot(w_idx);
          w_a_nxt     = op_a[w_idx*WIDTH +: WIDTH];
          w_b_nxt     = op_b[w_idx*WIDTH +: WIDTH];
          w_ptr_nxt   = w_idx + 3'd1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        {w_cout_nxt, w_sum_nxt} = w_add;
        w_ack_nxt   = r_gnt;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
      r_ptr   <= w_ptr_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] op_a;
  logic [8*W-1:0] op_b;
  logic [7:0]     gnt;
  logic [7:0]     ack;
  logic [W-1:0]   sum;
  logic           cout;
  logic           busy;

  int unsigned total;
  int unsigned bad;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op_a  (op_a),
    .op_b  (op_b),
    .gnt   (gnt),
    .ack   (ack),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    int unsigned win;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_lanes();
    for (int i = 0; i < 8; i++) begin
      op_a[i*W +: W] = 32'hA000_0000 + 32'(i);
      op_b[i*W +: W] = 32'h0B00_0000 + 32'(i);
    end
  endtask

  function automatic logic [7:0] oh(input int unsigned i);
    logic [7:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int unsigned nack;
    int unsigned last_cyc;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;

    // Run back to back from reset, ptr starting at 0; winners worked by hand.
    vecs[0] = '{req: 8'h04, win: 2, a: 32'd5,          b: 32'd7,          s: 32'd12,         c: 1'b0}; // ptr->3
    vecs[1] = '{req: 8'h01, win: 0, a: 32'hFFFF_FFFF,  b: 32'd1,          s: 32'd0,          c: 1'b1}; // ptr->1
    vecs[2] = '{req: 8'h81, win: 7, a: 32'h1234_5678,  b: 32'h1111_1111,  s: 32'h2345_6789,  c: 1'b0}; // ptr->0
    vecs[3] = '{req: 8'h81, win: 0, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  s: 32'hFFFF_FFFE,  c: 1'b1}; // ptr->1
    vecs[4] = '{req: 8'h30, win: 4, a: 32'd100,        b: 32'd200,        s: 32'd300,        c: 1'b0}; // ptr->5
    vecs[5] = '{req: 8'h30, win: 5, a: 32'd0,          b: 32'd0,          s: 32'd0,          c: 1'b0}; // ptr->6
    vecs[6] = '{req: 8'h0F, win: 0, a: 32'd7,          b: 32'hFFFF_FFF9,  s: 32'd0,          c: 1'b1}; // ptr->1

    do_reset();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_sum", 64'(sum), 64'h0);
    chk("rst_cout", 64'(cout), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // Table-driven single transactions; req dropped during EXEC each time.
    for (int i = 0; i < 7; i++) begin
      fill_lanes();
      op_a[vecs[i].win*W +: W] = vecs[i].a;
      op_b[vecs[i].win*W +: W] = vecs[i].b;
      req = vecs[i].req;
      tick();
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(oh(vecs[i].win)));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
      chk($sformatf("v%0d_ack_early", i), 64'(ack), 64'h0);
      req = '0;
      tick();
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(oh(vecs[i].win)));
      chk($sformatf("v%0d_sum", i), 64'(sum), 64'(vecs[i].s));
      chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].c));
      chk($sformatf("v%0d_gnt_hold", i), 64'(gnt), 64'(oh(vecs[i].win)));
      tick();
      chk($sformatf("v%0d_ack_off", i), 64'(ack), 64'h0);
      chk($sformatf("v%0d_gnt_off", i), 64'(gnt), 64'h0);
      chk($sformatf("v%0d_busy_off", i), 64'(busy), 64'h0);
      chk($sformatf("v%0d_sum_hold", i), 64'(sum), 64'(vecs[i].s));
    end

    // Round-robin with all requesters held: acks 0..7,0, three cycles apart.
    do_reset();
    fill_lanes();
    req      = 8'hFF;
    nack     = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && nack < 9; cyc++) begin
      tick();
      chk("rr_gnt_onehot0", 64'($onehot0(gnt)), 64'h1);
      chk("rr_ack_onehot0", 64'($onehot0(ack)), 64'h1);
      if (ack != 8'h00) begin
        chk($sformatf("rr_ack%0d", nack), 64'(ack), 64'(oh(nack % 8)));
        if (nack > 0) chk($sformatf("rr_gap%0d", nack), 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        nack++;
      end
    end
    chk("rr_ack_count", 64'(nack), 64'd9);
    req = '0;
    repeat (3) tick();

    // Wrap: grant 6, then req 0x41 -> 0 (search from 7), then 6.
    do_reset();
    fill_lanes();
    req = 8'h40;
    tick();
    chk("wrap_g6", 64'(gnt), 64'h40);
    req = 8'h41;
    tick();
    tick();
    tick();
    chk("wrap_g0", 64'(gnt), 64'h01);
    tick();
    tick();
    tick();
    chk("wrap_g6b", 64'(gnt), 64'h40);
    req = '0;
    repeat (3) tick();

    // Operand and req change after grant must not affect the result.
    do_reset();
    fill_lanes();
    op_a[3*W +: W] = 32'd10;
    op_b[3*W +: W] = 32'd20;
    req = 8'h08;
    tick();
    chk("latch_gnt", 64'(gnt), 64'h08);
    op_a[3*W +: W] = 32'd999;
    op_b[3*W +: W] = 32'd555;
    req = '0;
    tick();
    chk("latch_ack", 64'(ack), 64'h08);
    chk("latch_sum", 64'(sum), 64'd30);
    tick();

    // Reset during EXEC with ptr already advanced: abort, then search from 0.
    do_reset();
    fill_lanes();
    req = 8'h04;
    tick();
    req = '0;
    tick();
    chk("pre_rst_sum", 64'(sum), 64'(32'hA000_0002 + 32'h0B00_0002));
    tick();
    req = 8'h10;
    tick();
    chk("pre_rst_gnt", 64'(gnt), 64'h10);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'h0);
    chk("arst_ack", 64'(ack), 64'h0);
    chk("arst_sum", 64'(sum), 64'h0);
    chk("arst_cout", 64'(cout), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    tick();
    chk("arst_ack_hold", 64'(ack), 64'h0);
    rst_n = 1'b1;
    // 0x42: ptr 0 picks 1, a stale ptr of 5 would pick 6.
    req = 8'h42;
    tick();
    chk("post_rst_gnt", 64'(gnt), 64'h02);
    req = '0;
    tick();
    chk("post_rst_ack", 64'(ack), 64'h02);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
